scoreboard_hazard_unit: RTL and testbench

// Parametrised ID-stage hazard/scoreboard unit for the pipelined MIPS core with variable-latency EX units (ALU, mul, div).

---
 rtl/scoreboard_hazard_unit_pkg.sv | 16 +
 rtl/scoreboard_hazard_unit_wb_slot_reserve.sv | 55 +++++
 rtl/scoreboard_hazard_unit.sv | 154 +++++++++++++++
 tb/tb_scoreboard_hazard_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/scoreboard_hazard_unit_pkg.sv
// Shared constants for the ID-stage scoreboard / hazard unit.
//   SB_REG_AW  : default register address width (32 architectural registers)
//   SB_MAX_LAT : default longest EX latency, issue to result on the bypass network
//   SB_LAT_W   : default width of latency fields and per-register countdowns
//   LAT_ALU/LAT_MUL/LAT_DIV : latency codes the decoder attaches to each EX class
package scoreboard_hazard_unit_pkg;

    localparam int SB_REG_AW  = 5;
    localparam int SB_MAX_LAT = 8;
    localparam int SB_LAT_W   = 4;

    localparam logic [SB_LAT_W-1:0] LAT_ALU = 4'd1;
    localparam logic [SB_LAT_W-1:0] LAT_MUL = 4'd4;
    localparam logic [SB_LAT_W-1:0] LAT_DIV = 4'd8;

endpackage

// File: rtl/scoreboard_hazard_unit_wb_slot_reserve.sv
// Write-port slot reservation for the single register-file write port.
// Bit k of the reservation vector means a result lands on the bypass network
// k cycles from now. The vector shifts toward index 1 every cycle.
// Ports:
//   clock, reset : core clock, synchronous active-low reset
//   set_en       : an instruction with effective latency set_lat issues now
//   set_lat      : effective latency (1..MAX_LAT) of the issuing instruction
//   query_lat    : effective latency of the instruction currently in ID
//   query_hit    : a completion is already booked query_lat cycles from now
module scoreboard_hazard_unit_wb_slot_reserve
    import scoreboard_hazard_unit_pkg::*;
#(
    parameter int MAX_LAT = SB_MAX_LAT,
    parameter int LAT_W   = SB_LAT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             set_en,
    input  logic [LAT_W-1:0] set_lat,
    input  logic [LAT_W-1:0] query_lat,
    output logic             query_hit
);

    logic [MAX_LAT:1] resv_r;
    logic [MAX_LAT:1] resv_next_s;

    // Shift toward completion and book the new result. After the shift an
    // instruction of latency L is L-1 cycles away, so it lands in slot L-1;
    // L==1 completes next cycle and needs no booking ahead.
    always_comb begin
        resv_next_s = {MAX_LAT{1'b0}};
        for (int k = 1; k < MAX_LAT; k++) begin
            resv_next_s[k] = resv_r[k+1] | (set_en & (set_lat == LAT_W'(k + 1)));
        end
        resv_next_s[MAX_LAT] = 1'b0;
    end

    // Look up the slot the ID-stage instruction would complete in.
    always_comb begin
        query_hit = 1'b0;
        for (int k = 1; k <= MAX_LAT; k++) begin
            query_hit = query_hit | (resv_r[k] & (query_lat == LAT_W'(k)));
        end
    end

    // Reservation register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            resv_r <= {MAX_LAT{1'b0}};
        end else begin
            resv_r <= resv_next_s;
        end
    end

endmodule

// File: rtl/scoreboard_hazard_unit.sv
// ID-stage scoreboard and hazard unit for the pipelined MIPS core with
// variable-latency EX units. Keeps a busy flag and a countdown to "result on
// bypass network" per architectural register, and stalls ID on RAW, WAW and
// write-port (structural) hazards. All decisions use registered state only;
// a writeback in the same cycle does not release a stall until next cycle.
// Ports:
//   clock, reset            : core clock, synchronous active-low reset
//   id_valid, id_flush      : instruction present in ID / squash it
//   id_rs, id_rt, *_used    : source registers and whether they are read
//   id_wr_en, id_rd, id_lat : destination write, register and EX latency
//   wb_en, wb_rd            : writeback retiring a pending entry
//   stall                   : hold ID and inject an ID/EX bubble
//   PC_write, IFID_write    : front-end write enables (~stall)
//   issue_ok                : instruction leaves ID this cycle
//   rs_bypass, rt_bypass    : operand must come from the bypass network
module scoreboard_hazard_unit
    import scoreboard_hazard_unit_pkg::*;
#(
    parameter int REG_AW  = SB_REG_AW,
    parameter int MAX_LAT = SB_MAX_LAT,
    parameter int LAT_W   = SB_LAT_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic              id_wr_en,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [LAT_W-1:0]  id_lat,
    input  logic              id_flush,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_rd,
    output logic              stall,
    output logic              PC_write,
    output logic              IFID_write,
    output logic              issue_ok,
    output logic              rs_bypass,
    output logic              rt_bypass
);

    localparam int NUM_REGS = 1 << REG_AW;

    // Latency 0 is treated as a single-cycle op; anything beyond the longest
    // unit is capped so countdowns and slot indices stay in range.
    function automatic logic [LAT_W-1:0] clamp_lat(input logic [LAT_W-1:0] lat);
        logic [LAT_W-1:0] res;
        if (lat == {LAT_W{1'b0}}) begin
            res = LAT_W'(1);
        end else if (lat > LAT_W'(MAX_LAT)) begin
            res = LAT_W'(MAX_LAT);
        end else begin
            res = lat;
        end
        return res;
    endfunction

    logic [NUM_REGS-1:0] busy_r;
    logic [NUM_REGS-1:0] busy_next_s;
    logic [LAT_W-1:0]    cnt_r      [NUM_REGS];
    logic [LAT_W-1:0]    cnt_next_s [NUM_REGS];

    logic [LAT_W-1:0] eff_lat_s;
    logic             rs_chk_s;
    logic             rt_chk_s;
    logic             raw_s;
    logic             waw_s;
    logic             struct_s;
    logic             slot_hit_s;
    logic             stall_s;
    logic             issue_s;
    logic             alloc_s;
    logic             rs_byp_s;
    logic             rt_byp_s;

    // Hazard detection from registered scoreboard state.
    always_comb begin
        eff_lat_s = clamp_lat(id_lat);
        rs_chk_s  = id_rs_used && (id_rs != REG_AW'(0)) && busy_r[id_rs];
        rt_chk_s  = id_rt_used && (id_rt != REG_AW'(0)) && busy_r[id_rt];
        // A busy source whose countdown reached zero is on the bypass network.
        rs_byp_s  = rs_chk_s && (cnt_r[id_rs] == {LAT_W{1'b0}});
        rt_byp_s  = rt_chk_s && (cnt_r[id_rt] == {LAT_W{1'b0}});
        raw_s     = (rs_chk_s && (cnt_r[id_rs] != {LAT_W{1'b0}})) ||
                    (rt_chk_s && (cnt_r[id_rt] != {LAT_W{1'b0}}));
        // Younger write must not complete before or with the older one.
        waw_s     = id_wr_en && (id_rd != REG_AW'(0)) && busy_r[id_rd] &&
                    (cnt_r[id_rd] >= eff_lat_s);
        struct_s  = id_wr_en && slot_hit_s;
        stall_s   = id_valid && !id_flush && (raw_s || waw_s || struct_s);
        issue_s   = id_valid && !id_flush && !stall_s;
        alloc_s   = issue_s && id_wr_en && (id_rd != REG_AW'(0));
    end

    // Per-register next state: allocation beats a same-cycle writeback,
    // writeback clears, otherwise the countdown runs toward zero.
    always_comb begin
        busy_next_s = busy_r;
        cnt_next_s  = cnt_r;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (r == 0) begin
                busy_next_s[r] = 1'b0;
                cnt_next_s[r]  = {LAT_W{1'b0}};
            end else if (alloc_s && (id_rd == REG_AW'(r))) begin
                busy_next_s[r] = 1'b1;
                cnt_next_s[r]  = eff_lat_s - LAT_W'(1);
            end else if (wb_en && (wb_rd == REG_AW'(r))) begin
                busy_next_s[r] = 1'b0;
                cnt_next_s[r]  = {LAT_W{1'b0}};
            end else if (cnt_r[r] != {LAT_W{1'b0}}) begin
                busy_next_s[r] = busy_r[r];
                cnt_next_s[r]  = cnt_r[r] - LAT_W'(1);
            end else begin
                busy_next_s[r] = busy_r[r];
                cnt_next_s[r]  = cnt_r[r];
            end
        end
    end

    // Scoreboard registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            busy_r <= {NUM_REGS{1'b0}};
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_r[r] <= {LAT_W{1'b0}};
            end
        end else begin
            busy_r <= busy_next_s;
            cnt_r  <= cnt_next_s;
        end
    end

    scoreboard_hazard_unit_wb_slot_reserve #(
        .MAX_LAT (MAX_LAT),
        .LAT_W   (LAT_W)
    ) u_slot (
        .clock     (clock),
        .reset     (reset),
        .set_en    (alloc_s),
        .set_lat   (eff_lat_s),
        .query_lat (eff_lat_s),
        .query_hit (slot_hit_s)
    );

    assign stall      = stall_s;
    assign PC_write   = ~stall_s;
    assign IFID_write = ~stall_s;
    assign issue_ok   = issue_s;
    assign rs_bypass  = rs_byp_s;
    assign rt_bypass  = rt_byp_s;

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Directed bench for scoreboard_hazard_unit: inputs applied on the falling
// edge, outputs checked 1 time unit later against hand-computed values.
module tb_scoreboard_hazard_unit;
    import scoreboard_hazard_unit_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs = 5'd0;
    logic [4:0] id_rt = 5'd0;
    logic       id_rs_used = 1'b0;
    logic       id_rt_used = 1'b0;
    logic       id_wr_en = 1'b0;
    logic [4:0] id_rd = 5'd0;
    logic [3:0] id_lat = 4'd0;
    logic       id_flush = 1'b0;
    logic       wb_en = 1'b0;
    logic [4:0] wb_rd = 5'd0;
    logic       stall;
    logic       PC_write;
    logic       IFID_write;
    logic       issue_ok;
    logic       rs_bypass;
    logic       rt_bypass;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    scoreboard_hazard_unit dut (
        .clock      (clock),
        .reset      (reset),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_rs_used (id_rs_used),
        .id_rt_used (id_rt_used),
        .id_wr_en   (id_wr_en),
        .id_rd      (id_rd),
        .id_lat     (id_lat),
        .id_flush   (id_flush),
        .wb_en      (wb_en),
        .wb_rd      (wb_rd),
        .stall      (stall),
        .PC_write   (PC_write),
        .IFID_write (IFID_write),
        .issue_ok   (issue_ok),
        .rs_bypass  (rs_bypass),
        .rt_bypass  (rt_bypass)
    );

    task automatic check_eq(input string tag, input logic obs, input logic exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input int valid, input int rs, input int rs_used,
                         input int rt, input int rt_used, input int wr,
                         input int rd, input int lat, input int flush,
                         input int wbe, input int wbr);
        @(negedge clock);
        id_valid   = 1'(valid);
        id_rs      = 5'(rs);
        id_rs_used = 1'(rs_used);
        id_rt      = 5'(rt);
        id_rt_used = 1'(rt_used);
        id_wr_en   = 1'(wr);
        id_rd      = 5'(rd);
        id_lat     = 4'(lat);
        id_flush   = 1'(flush);
        wb_en      = 1'(wbe);
        wb_rd      = 5'(wbr);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic s, input logic iss,
                              input logic rb, input logic tb);
        check_eq({tag, ".stall"}, stall, s);
        check_eq({tag, ".pc_write"}, PC_write, ~s);
        check_eq({tag, ".ifid_write"}, IFID_write, ~s);
        check_eq({tag, ".issue_ok"}, issue_ok, iss);
        check_eq({tag, ".rs_bypass"}, rs_bypass, rb);
        check_eq({tag, ".rt_bypass"}, rt_bypass, tb);
    endtask

    initial begin
        // Reset held low for two edges with a reader of r3 in ID.
        for (int i = 0; i < 2; i++) begin
            drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
            check_eq("reset.stall", stall, 1'b0);
            check_eq("reset.pc_write", PC_write, 1'b1);
            check_eq("reset.ifid_write", IFID_write, 1'b1);
            check_eq("reset.rs_bypass", rs_bypass, 1'b0);
            check_eq("reset.rt_bypass", rt_bypass, 1'b0);
        end
        reset = 1'b1;
        drive(1, 3, 1, 5, 1, 0, 0, 0, 0, 0, 0);
        expect_out("post_reset", 1'b0, 1'b1, 1'b0, 1'b0);

        // RAW: MUL r5 (lat 4), reader waits 3 cycles then bypasses.
        drive(1, 0, 0, 0, 0, 1, 5, int'(LAT_MUL), 0, 0, 0);
        expect_out("raw_mul", 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 5, 1, 0, 1, 1, 9, int'(LAT_ALU), 0, 0, 0);
            expect_out("raw_wait", 1'b1, 1'b0, 1'b0, 1'b0);
        end
        drive(1, 5, 1, 0, 1, 1, 9, int'(LAT_ALU), 0, 0, 0);
        expect_out("raw_go", 1'b0, 1'b1, 1'b1, 1'b0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5);
        expect_out("wb5", 1'b0, 1'b0, 1'b0, 1'b0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
        expect_out("wb9", 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1, 5, 1, 9, 1, 0, 0, 0, 0, 0, 0);
        expect_out("raw_clear", 1'b0, 1'b1, 1'b0, 1'b0);

        // WAW: DIV r7 (lat 8) then ALU r7 (lat 1) waits until cnt[7]==0.
        drive(1, 0, 0, 0, 0, 1, 7, int'(LAT_DIV), 0, 0, 0);
        expect_out("waw_div", 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            drive(1, 0, 0, 0, 0, 1, 7, int'(LAT_ALU), 0, 0, 0);
            expect_out("waw_wait", 1'b1, 1'b0, 1'b0, 1'b0);
        end
        drive(1, 0, 0, 0, 0, 1, 7, int'(LAT_ALU), 0, 0, 0);
        expect_out("waw_go", 1'b0, 1'b1, 1'b0, 1'b0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
        expect_out("wb7", 1'b0, 1'b0, 1'b0, 1'b0);

        // STRUCT: lat 3 to r2 then lat 2 to r4 collide on the write port.
        drive(1, 0, 0, 0, 0, 1, 2, 3, 0, 0, 0);
        expect_out("st_a", 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1, 0, 0, 0, 0, 1, 4, 2, 0, 0, 0);
        expect_out("st_clash", 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1, 0, 0, 0, 0, 1, 4, 2, 0, 0, 0);
        expect_out("st_go", 1'b0, 1'b1, 1'b0, 1'b0);
        // r2 ready (bypass), r4 one cycle out; same-cycle wb r2 has no effect yet.
        drive(1, 2, 1, 4, 1, 0, 0, 0, 0, 1, 2);
        expect_out("st_rd", 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1, 2, 1, 4, 1, 0, 0, 0, 0, 1, 4);
        expect_out("st_rd2", 1'b0, 1'b1, 1'b0, 1'b1);
        drive(1, 2, 1, 4, 1, 0, 0, 0, 0, 0, 0);
        expect_out("st_clear", 1'b0, 1'b1, 1'b0, 1'b0);

        // Same-cycle writeback and re-issue of r6: issue wins.
        drive(1, 0, 0, 0, 0, 1, 6, 1, 0, 0, 0);
        expect_out("sim_a", 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1, 0, 0, 0, 0, 1, 6, 3, 0, 1, 6);
        expect_out("sim_b", 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("sim_busy", 1'b1, 1'b0, 1'b0, 1'b0);
        // Flush with a RAW source: no stall, no entry for r11.
        drive(1, 6, 1, 0, 0, 1, 11, 1, 1, 0, 0);
        expect_out("flush", 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1, 11, 1, 6, 1, 0, 0, 0, 0, 1, 6);
        expect_out("flush_chk", 1'b0, 1'b1, 1'b0, 1'b1);

        // Register 0: never busy, never reserves a slot.
        drive(1, 0, 0, 0, 0, 1, 0, 8, 0, 0, 0);
        expect_out("r0_wr", 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1, 0, 1, 0, 1, 1, 0, 8, 0, 0, 0);
        expect_out("r0_rd", 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1, 0, 0, 0, 0, 1, 12, 7, 0, 0, 0);
        expect_out("r0_slot", 1'b0, 1'b1, 1'b0, 1'b0);

        // Latency clamping: 15 acts as 8, 0 acts as 1.
        drive(1, 0, 0, 0, 0, 1, 13, 15, 0, 0, 0);
        expect_out("clamp_hi", 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1, 0, 0, 0, 0, 1, 14, 7, 0, 0, 0);
        expect_out("clamp_hi_slot", 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1, 0, 0, 0, 0, 1, 16, 0, 0, 0, 0);
        expect_out("clamp_lo", 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1, 16, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("clamp_lo_rd", 1'b0, 1'b1, 1'b1, 1'b0);

        // Reset mid-operation discards r12/r13/r16 entries and reservations.
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        drive(1, 13, 1, 16, 1, 1, 14, 7, 0, 0, 0);
        expect_out("rst_mid", 1'b0, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
